// File: rtl/inner_prod_accum.sv
// -----------------------------------------------------------------------------
// inner_prod_accum
//
// Sums windows of signed inner-product samples and queues each finished window
// sum in a 2-entry first-word-fall-through output FIFO.
//
// Optional feature macro: INNER_PROD_ACCUM_SAT_EN
//   defined   -> every addition clips to the signed ACC_WIDTH range and
//                out_sat flags any result in which a clip occurred
//   undefined -> additions wrap modulo 2^ACC_WIDTH, out_sat is always 0
//
// Ports
//   clk              in   clock, rising edge
//   arst_n           in   asynchronous active-low reset
//   clr              in   synchronous clear (partial sum, FIFO, drop_cnt)
//   inner_prod       in   DATA_WIDTH signed sample
//   inner_prod_valid in   sample qualifier, no backpressure
//   accum_len        in   LEN_WIDTH samples per window (0 acts as 1)
//   out_sum          out  ACC_WIDTH signed window sum at FIFO head
//   out_valid        out  FIFO not empty
//   out_ready        in   consumer accept
//   out_sat          out  head result was clipped
//   drop_cnt         out  8-bit saturating count of windows lost to a full FIFO
//   state_dbg        out  FSM state (0 = IDLE, 1 = ACC)
//
// Output handshake: a result transfers on every rising edge where
// out_valid && out_ready; while out_valid && !out_ready, out_sum and out_sat
// hold their value. The input side has no ready: a sample is taken on every
// edge where inner_prod_valid is high.
// -----------------------------------------------------------------------------
module inner_prod_accum #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 40,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] inner_prod,
    input  logic                  inner_prod_valid,
    input  logic [LEN_WIDTH-1:0]  accum_len,
    output logic [ACC_WIDTH-1:0]  out_sum,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sat,
    output logic [7:0]            drop_cnt,
    output logic                  state_dbg
);

    typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

    state_t                 state, state_nxt;
    logic [ACC_WIDTH-1:0]   acc, acc_nxt;
    logic [LEN_WIDTH-1:0]   cnt, cnt_nxt;
    logic [LEN_WIDTH-1:0]   len_q, len_nxt;
    logic                   win_sat, win_sat_nxt;
    logic [LEN_WIDTH-1:0]   len_eff;
    logic                   last_in_win;

    logic [ACC_WIDTH-1:0]   sample_ext;
    logic [ACC_WIDTH-1:0]   add_res;
    logic                   add_clip;

    logic                   push;
    logic                   push_req;
    logic [ACC_WIDTH-1:0]   push_sum;
    logic                   push_sat;

    logic [ACC_WIDTH-1:0]   mem_sum [2];
    logic                   mem_sat [2];
    logic                   wr_ptr, rd_ptr;
    logic [1:0]             fcnt;
    logic                   full, pop, push_ok, drop;

    // ---------------------------------------------------------------- datapath
    generate
        if (ACC_WIDTH > DATA_WIDTH) begin : g_ext
            assign sample_ext = {{(ACC_WIDTH-DATA_WIDTH){inner_prod[DATA_WIDTH-1]}}, inner_prod};
        end else begin : g_noext
            assign sample_ext = inner_prod;
        end
    endgenerate

`ifdef INNER_PROD_ACCUM_SAT_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    logic [ACC_WIDTH-1:0] raw_sum;

    // Signed overflow: both operands share a sign and the sum's sign differs.
    always_comb begin
        raw_sum  = acc + sample_ext;
        add_clip = (acc[ACC_WIDTH-1] == sample_ext[ACC_WIDTH-1]) &&
                   (raw_sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
        add_res  = add_clip ? (acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX) : raw_sum;
    end
`else
    always_comb begin
        add_res  = acc + sample_ext;
        add_clip = 1'b0;
    end
`endif

    assign len_eff     = (accum_len == '0) ? LEN_WIDTH'(1) : accum_len;
    assign last_in_win = ((cnt + LEN_WIDTH'(1)) == len_q);

    // --------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else if (inner_prod_valid) begin
            case (state)
                IDLE:    state_nxt = (len_eff == LEN_WIDTH'(1)) ? IDLE : ACC;
                ACC:     state_nxt = last_in_win ? IDLE : ACC;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Window bookkeeping and the push request for a completed window.
    always_comb begin
        push        = 1'b0;
        push_sum    = add_res;
        push_sat    = win_sat | add_clip;
        acc_nxt     = acc;
        cnt_nxt     = cnt;
        len_nxt     = len_q;
        win_sat_nxt = win_sat;
        if (inner_prod_valid) begin
            case (state)
                IDLE: begin
                    // accum_len is only sampled here, so mid-window changes wait.
                    len_nxt     = len_eff;
                    acc_nxt     = sample_ext;
                    cnt_nxt     = LEN_WIDTH'(1);
                    win_sat_nxt = 1'b0;
                    if (len_eff == LEN_WIDTH'(1)) begin
                        push     = 1'b1;
                        push_sum = sample_ext;
                        push_sat = 1'b0;
                        acc_nxt  = '0;
                        cnt_nxt  = '0;
                    end
                end
                ACC: begin
                    if (last_in_win) begin
                        push        = 1'b1;
                        acc_nxt     = '0;
                        cnt_nxt     = '0;
                        win_sat_nxt = 1'b0;
                    end else begin
                        acc_nxt     = add_res;
                        cnt_nxt     = cnt + LEN_WIDTH'(1);
                        win_sat_nxt = push_sat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state_dbg = (state == ACC);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            acc     <= '0;
            cnt     <= '0;
            len_q   <= LEN_WIDTH'(1);
            win_sat <= 1'b0;
        end else if (clr) begin
            acc     <= '0;
            cnt     <= '0;
            len_q   <= LEN_WIDTH'(1);
            win_sat <= 1'b0;
        end else begin
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            len_q   <= len_nxt;
            win_sat <= win_sat_nxt;
        end
    end

    // -------------------------------------------------------------- output FIFO
    // clr discards a same-cycle completion along with the sample itself.
    assign push_req  = push && !clr;
    assign out_valid = (fcnt != 2'd0);
    assign full      = (fcnt == 2'd2);
    assign pop       = out_valid && out_ready;
    // When full, the slot being popped is the one written, so push+pop is safe.
    assign push_ok   = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    assign out_sum = out_valid ? mem_sum[rd_ptr] : '0;
    assign out_sat = out_valid & mem_sat[rd_ptr];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_sum[i] <= '0;
                mem_sat[i] <= 1'b0;
            end
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fcnt     <= 2'd0;
            drop_cnt <= 8'd0;
        end else if (clr) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fcnt     <= 2'd0;
            drop_cnt <= 8'd0;
        end else begin
            if (push_ok) begin
                mem_sum[wr_ptr] <= push_sum;
                mem_sat[wr_ptr] <= push_sat;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push_ok, pop})
                2'b10:   fcnt <= fcnt + 2'd1;
                2'b01:   fcnt <= fcnt - 2'd1;
                default: fcnt <= fcnt;
            endcase
            if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_inner_prod_accum.sv
// -----------------------------------------------------------------------------
// tb_inner_prod_accum
//
// Bench for inner_prod_accum. A behavioural window/FIFO model pushes expected
// sums into exp_q as samples are driven; a monitor pops and compares them on
// every accepted output. A second 8-bit instance covers wrap vs. clip.
// -----------------------------------------------------------------------------
module tb_inner_prod_accum;

    localparam int DW = 32;
    localparam int AW = 40;
    localparam int LW = 8;

    // ------------------------------------------------------- clock and reset
    logic clk    = 1'b0;
    logic arst_n = 1'b0;
    logic clr    = 1'b0;

    always #5 clk = ~clk;

    // ----------------------------------------------------------- main DUT I/O
    logic [DW-1:0] inner_prod       = '0;
    logic          inner_prod_valid = 1'b0;
    logic [LW-1:0] accum_len        = 8'd4;
    logic          out_ready        = 1'b1;
    logic [AW-1:0] out_sum;
    logic          out_valid;
    logic          out_sat;
    logic [7:0]    drop_cnt;
    logic          state_dbg;

    inner_prod_accum #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .clr              (clr),
        .inner_prod       (inner_prod),
        .inner_prod_valid (inner_prod_valid),
        .accum_len        (accum_len),
        .out_sum          (out_sum),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_sat          (out_sat),
        .drop_cnt         (drop_cnt),
        .state_dbg        (state_dbg)
    );

    // ------------------------------------------------------ 8-bit DUT I/O
    logic [7:0] b_ip    = '0;
    logic       b_valid = 1'b0;
    logic [7:0] b_len   = 8'd2;
    logic       b_ready = 1'b1;
    logic [7:0] b_sum;
    logic       b_out_valid;
    logic       b_sat;
    logic [7:0] b_drop;
    logic       b_state;

    inner_prod_accum #(.DATA_WIDTH(8), .ACC_WIDTH(8), .LEN_WIDTH(8)) dut8 (
        .clk              (clk),
        .arst_n           (arst_n),
        .clr              (clr),
        .inner_prod       (b_ip),
        .inner_prod_valid (b_valid),
        .accum_len        (b_len),
        .out_sum          (b_sum),
        .out_valid        (b_out_valid),
        .out_ready        (b_ready),
        .out_sat          (b_sat),
        .drop_cnt         (b_drop),
        .state_dbg        (b_state)
    );

    // ------------------------------------------------------------- checking
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] s40(input longint v);
        return v[AW-1:0];
    endfunction

    // ------------------------------------------------------------ scoreboard
    logic [AW-1:0] exp_q[$];
    bit            m_in_win = 1'b0;
    int            m_len    = 1;
    int            m_n      = 0;
    longint        m_acc    = 0;
    int            m_fcnt   = 0;
    int            m_drop   = 0;
    longint        seen_n   = 0;
    logic [AW-1:0] last_seen = '0;

    always @(posedge clk) begin : model_blk
        bit     pop_now;
        bit     done;
        longint s;
        if (!arst_n || clr) begin
            m_in_win = 1'b0;
            m_n      = 0;
            m_acc    = 0;
            m_fcnt   = 0;
            m_drop   = 0;
            exp_q.delete();
        end else begin
            pop_now = out_ready && (m_fcnt > 0);
            done    = 1'b0;
            if (inner_prod_valid) begin
                s = longint'($signed(inner_prod));
                if (!m_in_win) begin
                    m_len = (accum_len == 0) ? 1 : int'(accum_len);
                    m_acc = s;
                    m_n   = 1;
                end else begin
                    m_acc = m_acc + s;
                    m_n   = m_n + 1;
                end
                if (m_n == m_len) begin
                    done     = 1'b1;
                    m_in_win = 1'b0;
                end else begin
                    m_in_win = 1'b1;
                end
            end
            if (done) begin
                if (m_fcnt == 2 && !pop_now) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    exp_q.push_back(s40(m_acc));
                    m_fcnt++;
                end
            end
            if (pop_now) m_fcnt--;
        end
    end

    always @(negedge clk) begin : monitor_blk
        logic [AW-1:0] e;
        #1;
        if (arst_n) begin
            check("valid_vs_model", out_valid, m_fcnt > 0);
            check("drop_vs_model", drop_cnt, m_drop);
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sb_sum", out_sum, e);
                    check("sb_sat", out_sat, 1'b0);
                end else begin
                    check("sb_nonempty", exp_q.size(), 1);
                end
                seen_n++;
                last_seen = out_sum;
            end
        end
    end

    // -------------------------------------------------------------- drivers
    task automatic send(input longint v);
        inner_prod       = v[DW-1:0];
        inner_prod_valid = 1'b1;
        @(negedge clk);
        inner_prod_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    // -------------------------------------------------------------- watchdog
    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog timeout");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    // -------------------------------------------------------------- stimulus
    initial begin
        longint n0;
        logic [7:0] e8;
        logic       es8;

        #2;
        check("rst_valid", out_valid, 1'b0);
        check("rst_sum", out_sum, '0);
        check("rst_sat", out_sat, 1'b0);
        check("rst_drop", drop_cnt, 8'd0);
        check("rst_state", state_dbg, 1'b0);
        @(negedge clk);
        arst_n = 1'b1;
        idle(1);

        // 4-sample window: 1+2+3-10 = -4, visible one cycle after the last sample
        accum_len = 8'd4;
        out_ready = 1'b1;
        n0 = seen_n;
        send(1); send(2); send(3);
        check("t1_state", state_dbg, 1'b1);
        check("t1_early", out_valid, 1'b0);
        send(-10);
        check("t1_valid", out_valid, 1'b1);
        check("t1_sum", out_sum, s40(-4));
        @(negedge clk);
        check("t1_valid_off", out_valid, 1'b0);
        idle(1);
        check("t1_count", seen_n - n0, 1);

        // accum_len 0 behaves as 1
        accum_len = 8'd0;
        n0 = seen_n;
        send(7);
        check("t2_first", out_sum, s40(7));
        send(8);
        check("t2_second", out_sum, s40(8));
        idle(2);
        check("t2_count", seen_n - n0, 2);

        // full FIFO drops the third result
        accum_len = 8'd1;
        out_ready = 1'b0;
        n0 = seen_n;
        send(5); send(6); send(7);
        check("t3_drop", drop_cnt, 8'd1);
        check("t3_head", out_sum, s40(5));
        idle(3);
        check("t3_hold", out_sum, s40(5));
        check("t3_hold_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        idle(3);
        check("t3_count", seen_n - n0, 2);
        check("t3_last", last_seen, s40(6));
        check("t3_drop_kept", drop_cnt, 8'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t3_clr_drop", drop_cnt, 8'd0);

        // 200 windows of 2 x 0x7FFFFFFF, back to back
        accum_len = 8'd2;
        n0 = seen_n;
        repeat (400) send(longint'(32'h7FFF_FFFF));
        idle(2);
        check("t4_count", seen_n - n0, 200);
        check("t4_last", last_seen, s40(64'h0_FFFF_FFFE));
        check("t4_drop", drop_cnt, 8'd0);

        // reset mid-window discards the partial sum
        accum_len = 8'd4;
        send(9); send(9);
        pulse_reset();
        check("t5_rst_state", state_dbg, 1'b0);
        check("t5_rst_valid", out_valid, 1'b0);
        n0 = seen_n;
        repeat (4) send(1);
        idle(2);
        check("t5_count", seen_n - n0, 1);
        check("t5_last", last_seen, s40(4));

        // clr mid-window, with a same-cycle sample that must be ignored
        send(9); send(9);
        clr              = 1'b1;
        inner_prod       = 32'd50;
        inner_prod_valid = 1'b1;
        @(negedge clk);
        clr              = 1'b0;
        inner_prod_valid = 1'b0;
        check("t6_clr_state", state_dbg, 1'b0);
        n0 = seen_n;
        repeat (4) send(1);
        idle(2);
        check("t6_count", seen_n - n0, 1);
        check("t6_last", last_seen, s40(4));

        // random samples, lengths changing every cycle, bursty consumer
        for (int i = 0; i < 300; i++) begin
            accum_len        = 8'($urandom_range(0, 5));
            out_ready        = ($urandom_range(0, 3) != 0);
            inner_prod_valid = ($urandom_range(0, 3) != 0);
            inner_prod       = 32'(int'($urandom_range(0, 2000)) - 1000);
            @(negedge clk);
        end
        inner_prod_valid = 1'b0;
        out_ready        = 1'b1;
        idle(5);
        check("t7_drained", exp_q.size(), 0);

        // 8-bit instance: 100 + 100 clips or wraps
`ifdef INNER_PROD_ACCUM_SAT_EN
        e8  = 8'h7F;
        es8 = 1'b1;
`else
        e8  = 8'hC8;
        es8 = 1'b0;
`endif
        b_len   = 8'd2;
        b_ready = 1'b1;
        b_ip    = 8'd100;
        b_valid = 1'b1;
        idle(2);
        b_valid = 1'b0;
        check("t8_valid", b_out_valid, 1'b1);
        check("t8_sum", b_sum, e8);
        check("t8_sat", b_sat, es8);
        idle(2);
        check("t8_popped", b_out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
